// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory access FSM and MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned load/store traps instead of accessing memory).
module mem_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_exe,
    input  logic [WIDTH-1:0] aluout_exe,
    input  logic [WIDTH-1:0] writedata_exe,
    input  logic [4:0]       writereg_exe,
    input  logic             regwrite_exe,
    input  logic             memtoreg_exe,
    input  logic             memread_exe,
    input  logic             memwrite_exe,
    output logic             stall_mem,
    output logic [WIDTH-1:0] aluout_mem,
    output logic [4:0]       writereg_mem,
    output logic             regwrite_mem,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ready,
    output logic [WIDTH-1:0] result_wb,
    output logic [4:0]       writereg_wb,
    output logic             regwrite_wb,
    output logic             misalign_wb
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic             ex_valid;
    logic [WIDTH-1:0] ex_aluout;
    logic [WIDTH-1:0] ex_wdata;
    logic [4:0]       ex_writereg;
    logic             ex_regwrite;
    logic             ex_memtoreg;
    logic             ex_memread;
    logic             ex_memwrite;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] rdata_q;
    logic             memop;
    logic             trap;
    logic             start;
    logic             accept;

    assign memop = ex_valid & (ex_memread | ex_memwrite);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = memop & (ex_aluout[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    // A new access starts only from IDLE; DONE means the EX/MEM op already finished.
    assign start  = (state == IDLE) & memop & ~trap;
    assign accept = (state == BUSY) & dmem_ready;

    always_comb begin
        stall_mem  = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                stall_mem = start;
                if (start) state_next = BUSY;
            end
            BUSY: begin
                stall_mem = 1'b1;
                if (dmem_ready) state_next = DONE;
            end
            DONE: begin
                stall_mem  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                stall_mem  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // EX/MEM register; a bubble clears valid and every control bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_aluout   <= '0;
            ex_wdata    <= '0;
            ex_writereg <= '0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else if (!stall_mem) begin
            ex_valid    <= valid_exe;
            ex_aluout   <= aluout_exe;
            ex_wdata    <= writedata_exe;
            ex_writereg <= writereg_exe;
            ex_regwrite <= valid_exe & regwrite_exe;
            ex_memtoreg <= valid_exe & memtoreg_exe;
            ex_memread  <= valid_exe & memread_exe;
            ex_memwrite <= valid_exe & memwrite_exe;
        end
    end

    assign aluout_mem   = ex_aluout;
    assign writereg_mem = ex_writereg;
    assign regwrite_mem = ex_valid & ex_regwrite;

    // Request outputs are loaded once on start and held untouched until the access is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_memwrite;
            dmem_addr  <= {ex_aluout[WIDTH-1:2], 2'b00};
            dmem_wdata <= ex_wdata;
        end else if (accept) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         rdata_q <= '0;
        else if (accept) rdata_q <= dmem_rdata;
    end

    // MEM/WB: a stalled cycle inserts a bubble so a held instruction writes back only once.
    always_ff @(posedge clk) begin
        if (rst || stall_mem) begin
            result_wb   <= '0;
            writereg_wb <= '0;
            regwrite_wb <= 1'b0;
        end else begin
            result_wb   <= (ex_memtoreg & ~trap) ? rdata_q : ex_aluout;
            writereg_wb <= ex_writereg;
            regwrite_wb <= ex_valid & ex_regwrite & ~ex_memwrite & ~trap;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst || stall_mem) misalign_q <= 1'b0;
        else                  misalign_q <= trap;
    end

    assign misalign_wb = misalign_q;
`else
    assign misalign_wb = 1'b0;
`endif

endmodule
